// File: rtl/burst_scheduler_pkg.sv
// TDMA burst scheduler shared package.
// State codes, default frame geometry and an index-width helper.
package burst_scheduler_pkg;

   localparam int DEF_NUM_SLOTS    = 8;
   localparam int DEF_SLOT_SYMBOLS = 156;
   localparam int DEF_FN_WIDTH     = 11;
   localparam int DEF_ACK_TIMEOUT  = 64;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_FIRED = 2'd2;
   localparam logic [1:0] ST_TX    = 2'd3;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/burst_scheduler_if.sv
// Scheduler <-> burst controller / host bundle.
// master drives requests, slave is the scheduler.
interface burst_scheduler_if
   import burst_scheduler_pkg::*;
#(
   parameter int NUM_SLOTS    = DEF_NUM_SLOTS,
   parameter int SLOT_SYMBOLS = DEF_SLOT_SYMBOLS,
   parameter int FN_WIDTH     = DEF_FN_WIDTH
);

   localparam int SLOT_W = idx_w(NUM_SLOTS);
   localparam int SYM_W  = idx_w(SLOT_SYMBOLS);

   logic                 symbol_strobe;
   logic                 enable;
   logic [NUM_SLOTS-1:0] slot_mask;
   logic                 mask_load;
   logic                 armed;
   logic                 txchain_en;
   logic                 fire_burst;
   logic [SLOT_W-1:0]    slot_index;
   logic [SYM_W-1:0]     symbol_index;
   logic [FN_WIDTH-1:0]  frame_number;
   logic                 missed_slot;
   logic                 ack_timeout;
   logic                 busy;

   modport master (
      output symbol_strobe, enable, slot_mask,
      output mask_load, armed, txchain_en,
      input  fire_burst, slot_index, symbol_index,
      input  frame_number, missed_slot,
      input  ack_timeout, busy
   );

   modport slave (
      input  symbol_strobe, enable, slot_mask,
      input  mask_load, armed, txchain_en,
      output fire_burst, slot_index, symbol_index,
      output frame_number, missed_slot,
      output ack_timeout, busy
   );

endinterface

// File: rtl/tdma_timebase.sv
// Symbol / slot / frame counter chain.
// Flags the slot start (symbol wrap) and the frame boundary.
module tdma_timebase
   import burst_scheduler_pkg::*;
#(
   parameter int  NUM_SLOTS    = DEF_NUM_SLOTS,
   parameter int  SLOT_SYMBOLS = DEF_SLOT_SYMBOLS,
   parameter int  FN_WIDTH     = DEF_FN_WIDTH,
   localparam int SLOT_W       = idx_w(NUM_SLOTS),
   localparam int SYM_W        = idx_w(SLOT_SYMBOLS)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                enable,
   input  logic                symbol_strobe,
   output logic [SYM_W-1:0]    symbol_index,
   output logic [SLOT_W-1:0]   slot_index,
   output logic [FN_WIDTH-1:0] frame_number,
   output logic                slot_start,
   output logic                frame_start,
   output logic [SLOT_W-1:0]   next_slot
);

   logic sym_last;
   logic slot_last;

   assign sym_last    = (symbol_index == SYM_W'(SLOT_SYMBOLS - 1));
   assign slot_last   = (slot_index == SLOT_W'(NUM_SLOTS - 1));
   assign slot_start  = enable && symbol_strobe && sym_last;
   assign frame_start = slot_start && slot_last;
   assign next_slot   = slot_last ? '0 : slot_index + SLOT_W'(1);

   // Counter chain; held at zero while disabled so a restart begins at 0/0/0
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         symbol_index <= '0;
         slot_index   <= '0;
         frame_number <= '0;
      end else if (!enable) begin
         symbol_index <= '0;
         slot_index   <= '0;
         frame_number <= '0;
      end else if (symbol_strobe) begin
         symbol_index <= sym_last ? '0 : symbol_index + SYM_W'(1);
         if (sym_last)
            slot_index <= next_slot;
         if (frame_start)
            frame_number <= frame_number + FN_WIDTH'(1);
      end
   end

endmodule

// File: rtl/burst_scheduler.sv
// TDMA burst scheduler top.
// Fires bursts on masked slot starts and tracks the burst handshake.
module burst_scheduler
   import burst_scheduler_pkg::*;
#(
   parameter int NUM_SLOTS    = DEF_NUM_SLOTS,
   parameter int SLOT_SYMBOLS = DEF_SLOT_SYMBOLS,
   parameter int FN_WIDTH     = DEF_FN_WIDTH,
   parameter int ACK_TIMEOUT  = DEF_ACK_TIMEOUT
) (
   input logic              clock,
   input logic              reset,
   burst_scheduler_if.slave bus
);

   localparam int SLOT_W = idx_w(NUM_SLOTS);
   localparam int TMR_W  = idx_w(ACK_TIMEOUT);

   logic [1:0]           state;
   logic [TMR_W-1:0]     timer;
   logic [NUM_SLOTS-1:0] pending;
   logic [NUM_SLOTS-1:0] active;
   logic [NUM_SLOTS-1:0] seed;
   logic [NUM_SLOTS-1:0] eff_mask;
   logic                 enable_q;
   logic                 en_rise;
   logic                 slot_start;
   logic                 frame_start;
   logic                 slot_hit;
   logic [SLOT_W-1:0]    next_slot;

   tdma_timebase #(
      .NUM_SLOTS    (NUM_SLOTS),
      .SLOT_SYMBOLS (SLOT_SYMBOLS),
      .FN_WIDTH     (FN_WIDTH)
   ) u_timebase (
      .clock         (clock),
      .reset         (reset),
      .enable        (bus.enable),
      .symbol_strobe (bus.symbol_strobe),
      .symbol_index  (bus.symbol_index),
      .slot_index    (bus.slot_index),
      .frame_number  (bus.frame_number),
      .slot_start    (slot_start),
      .frame_start   (frame_start),
      .next_slot     (next_slot)
   );

   // A load landing on the switch-over clock wins over the older pending value
   assign seed     = bus.mask_load ? bus.slot_mask : pending;
   assign eff_mask = (frame_start || en_rise) ? seed : active;
   assign en_rise  = bus.enable && !enable_q;
   assign slot_hit = slot_start && eff_mask[next_slot];
   assign bus.busy = (state == ST_FIRED) || (state == ST_TX);

   // Pending takes every load; active switches at frame boundaries and enable rise
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pending  <= '0;
         active   <= '0;
         enable_q <= 1'b0;
      end else begin
         enable_q <= bus.enable;
         if (bus.mask_load)
            pending <= bus.slot_mask;
         if (frame_start || en_rise)
            active <= seed;
      end
   end

   // Burst FSM with one-clock pulse outputs and the acknowledge timer
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state           <= ST_IDLE;
         timer           <= '0;
         bus.fire_burst  <= 1'b0;
         bus.missed_slot <= 1'b0;
         bus.ack_timeout <= 1'b0;
      end else begin
         bus.fire_burst  <= 1'b0;
         bus.missed_slot <= 1'b0;
         bus.ack_timeout <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (bus.enable)
                  state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (!bus.enable) begin
                  state <= ST_IDLE;
               end else if (slot_hit) begin
                  if (bus.armed) begin
                     bus.fire_burst <= 1'b1;
                     state          <= ST_FIRED;
                     timer          <= '0;
                  end else begin
                     bus.missed_slot <= 1'b1;
                  end
               end
            end
            ST_FIRED: begin
               if (!bus.enable) begin
                  state <= ST_IDLE;
               end else begin
                  if (slot_hit)
                     bus.missed_slot <= 1'b1;
                  if (bus.txchain_en) begin
                     state <= ST_TX;
                  end else if (timer == TMR_W'(ACK_TIMEOUT - 1)) begin
                     bus.ack_timeout <= 1'b1;
                     state           <= ST_WAIT;
                  end else begin
                     timer <= timer + TMR_W'(1);
                  end
               end
            end
            ST_TX: begin
               if (slot_hit)
                  bus.missed_slot <= 1'b1;
               if (!bus.txchain_en)
                  state <= bus.enable ? ST_WAIT : ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/burst_scheduler.md
BURST_SCHEDULER -- requirements
Module: burst_scheduler

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 8, meaning timeslots per frame.
REQ-002 SHALL have parameter SLOT_SYMBOLS, default 156, meaning symbol strobes per timeslot.
REQ-003 SHALL have parameter FN_WIDTH, default 11, meaning frame-number counter width.
REQ-004 SHALL have parameter ACK_TIMEOUT, default 64, meaning clocks allowed between fire_burst and txchain_en rising.
REQ-005 SHALL use one clock and an asynchronous, active-high reset: clock  input  1  system clock; reset  input  1  asynchronous active-high reset.
REQ-006 SHALL have port: symbol_strobe  input  1  one-clock pulse at symbol rate.
REQ-007 SHALL have port: enable  input  1  scheduler run control.
REQ-008 SHALL have port: slot_mask  input  NUM_SLOTS  per-slot transmit request, bit n = slot n.
REQ-009 SHALL have port: mask_load  input  1  one-clock pulse capturing slot_mask into the pending register.
REQ-010 SHALL have port: armed  input  1  burst controller ready to accept fire_burst.
REQ-011 SHALL have port: txchain_en  input  1  burst controller IQ-valid, high for the duration of a burst.
REQ-012 SHALL have port: fire_burst  output  1  one-clock pulse starting a burst.
REQ-013 SHALL have port: slot_index  output  clog2(NUM_SLOTS)  current timeslot.
REQ-014 SHALL have port: symbol_index  output  clog2(SLOT_SYMBOLS)  symbol position within the slot.
REQ-015 SHALL have port: frame_number  output  FN_WIDTH  current frame number.
REQ-016 SHALL have port: missed_slot  output  1  one-clock pulse when a masked slot could not fire.
REQ-017 SHALL have port: ack_timeout  output  1  one-clock pulse when txchain_en failed to rise.
REQ-018 SHALL have port: busy  output  1  high in FIRED or TX state.

Function
REQ-019 SHALL count symbol_index 0..SLOT_SYMBOLS-1, slot_index 0..NUM_SLOTS-1 and frame_number modulo 2^FN_WIDTH; all counters advance only on symbol_strobe while enable=1, with carry on wrap.
REQ-020 SHALL, on the rising edge of enable, start the counters at 0/0/0; when enable=0, counters SHALL hold at 0 and no fire_burst SHALL be issued.
REQ-021 SHALL implement states IDLE, WAIT, FIRED, TX: IDLE->WAIT when enable=1; WAIT->FIRED on fire; FIRED->TX when txchain_en=1; FIRED->WAIT on timeout; TX->WAIT when txchain_en falls; any state->IDLE when enable=0, except TX, which SHALL complete the in-flight burst first.
REQ-022 SHALL define a slot start as the clock on which symbol_strobe causes symbol_index to wrap to 0; the slot number is the new slot_index value.
REQ-023 SHALL pulse fire_burst on the clock after a slot start when the active mask bit for the new slot is 1, the state is WAIT and armed=1 (latency 1 clock).
REQ-024 SHALL pulse missed_slot instead of fire_burst when the active mask bit is 1 and either armed=0 or the state is FIRED/TX; the in-flight burst SHALL NOT be disturbed.
REQ-025 SHALL pulse ack_timeout and return to WAIT if txchain_en remains 0 for ACK_TIMEOUT clocks after fire_burst.
REQ-026 SHALL copy the pending mask into the active mask at each frame boundary (slot NUM_SLOTS-1 -> 0); a mask_load coinciding with the boundary SHALL have its new value committed for the new frame.
REQ-027 SHALL make slot 0 of the first frame after enable use the mask pending at the time of enable.
REQ-028 SHALL make slot_index, symbol_index and frame_number registered outputs that update on the clock following symbol_strobe.

Reset
REQ-029 SHALL on reset set the state to IDLE, all counters to 0, the pending and active masks to 0, and fire_burst, missed_slot, ack_timeout and busy to 0.
REQ-030 SHALL abandon any burst tracking on reset asserted mid-burst; no pulse output SHALL be generated during or on the clock after reset release.

Structure
REQ-031 SHALL take the state encoding and the default slot/frame constants from the shared modem package.
REQ-032 SHALL implement the symbol/slot/frame counter chain as one sub-module, tdma_timebase.

Verification
REQ-033 SHALL verify: NUM_SLOTS=8, SLOT_SYMBOLS=156, mask 0x01 loaded, enable, armed=1 -> fire_burst once per frame, one clock after slot 0 start, frame_number increments by 1 per frame.
REQ-034 SHALL verify: mask 0x81, armed=0 at slot 7 start -> missed_slot pulse, no fire_burst; slot 0 start with armed=1 -> fires.
REQ-035 SHALL verify: txchain_en held low after fire_burst -> ack_timeout exactly 64 clocks later, state back to WAIT.
REQ-036 SHALL verify: txchain_en held high across the next masked slot start -> missed_slot pulse, busy stays 1.
REQ-037 SHALL verify: mask_load 0x04 at the frame-boundary strobe -> slot 2 of the new frame fires; mask_load mid-frame -> takes effect only in the next frame.
REQ-038 SHALL verify: reset asserted during TX -> all outputs 0 asynchronously, IDLE, no pulses after release until the next masked slot start.
